if_id_pipe_reg: RTL and testbench

IF/ID pipeline register between the fetch stage and decode. Captures the fetched instruction and PC+4 each cycle. Supports a stall (hold) and a flush (bubble insertion). Presents the registered instruction pre-sliced into MIPS fields (immediate, shift amount, rt, rd, etc.) that feed the decode-side holder and the register file. Also keeps a saturating stall-cycle counter for performance debug.

---
 rtl/if_id_pipe_reg.sv | 113 +++++++++++
 tb/tb_if_id_pipe_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register.
// Captures the fetched instruction and PC+4 on each rising edge. A flush
// loads a bubble. A stall holds the current contents. The registered
// instruction is also presented already split into its MIPS fields.
// A saturating counter records the cycles in which a real (valid) entry
// was held by a stall, for performance debug.
module if_id_pipe_reg #(
  parameter int          ADDR_W      = 32,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0000,
  parameter int          STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      in_IF_PC_Plus4,
  input  logic [31:0]            in_IF_Instruction,
  input  logic                   in_IF_Valid,
  input  logic                   in_Stall,
  input  logic                   in_Flush,
  output logic [ADDR_W-1:0]      out_IF_ID_PC_Plus4,
  output logic [31:0]            out_IF_ID_Instruction,
  output logic                   out_IF_ID_Valid,
  output logic [5:0]             out_IF_ID_Opcode,
  output logic [4:0]             out_IF_ID_Rs_Address,
  output logic [4:0]             out_IF_ID_Rt_Address,
  output logic [4:0]             out_IF_ID_Rd_Address,
  output logic [4:0]             out_IF_ID_Shift_Amount,
  output logic [5:0]             out_IF_ID_Funct,
  output logic [15:0]            out_IF_ID_Immidiate,
  output logic [25:0]            out_IF_ID_Jump_Target,
  output logic [STALL_CNT_W-1:0] out_Stall_Count
);

  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  // Pipeline state
  logic [ADDR_W-1:0]      r_pc_plus4;
  logic [31:0]            r_instr;
  logic                   r_valid;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  // Next-state values
  logic [ADDR_W-1:0]      w_pc_plus4_nxt;
  logic [31:0]            w_instr_nxt;
  logic                   w_valid_nxt;
  logic [STALL_CNT_W-1:0] w_stall_cnt_nxt;
  logic                   w_cnt_sat;

  // The counter stops at all-ones and never wraps
  assign w_cnt_sat = &r_stall_cnt;

  // Next-state selection. Flush has priority over stall, and stall has
  // priority over load. A flush that coincides with a stall does not count.
  always_comb begin
    w_pc_plus4_nxt  = r_pc_plus4;
    w_instr_nxt     = r_instr;
    w_valid_nxt     = r_valid;
    w_stall_cnt_nxt = r_stall_cnt;
    if (in_Flush) begin
      // PC+4 is still captured so it can be seen when debugging.
      // Consumers must gate on Valid.
      w_instr_nxt    = NOP_INSTR;
      w_valid_nxt    = 1'b0;
      w_pc_plus4_nxt = in_IF_PC_Plus4;
    end else if (in_Stall) begin
      // Only a stall that holds a real instruction is counted.
      // A stall that holds a bubble is not.
      if (r_valid && !w_cnt_sat) begin
        w_stall_cnt_nxt = r_stall_cnt + CNT_ONE;
      end else begin
        w_stall_cnt_nxt = r_stall_cnt;
      end
    end else begin
      w_pc_plus4_nxt = in_IF_PC_Plus4;
      w_valid_nxt    = in_IF_Valid;
      if (in_IF_Valid) begin
        w_instr_nxt = in_IF_Instruction;
      end else begin
        w_instr_nxt = NOP_INSTR;
      end
    end
  end

  // State register with synchronous reset that overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc_plus4  <= {ADDR_W{1'b0}};
      r_instr     <= NOP_INSTR;
      r_valid     <= 1'b0;
      r_stall_cnt <= {STALL_CNT_W{1'b0}};
    end else begin
      r_pc_plus4  <= w_pc_plus4_nxt;
      r_instr     <= w_instr_nxt;
      r_valid     <= w_valid_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
    end
  end

  // Outputs come straight from the registers. The fields are plain slices,
  // so there is no combinational path from any input to any output.
  assign out_IF_ID_PC_Plus4     = r_pc_plus4;
  assign out_IF_ID_Instruction  = r_instr;
  assign out_IF_ID_Valid        = r_valid;
  assign out_Stall_Count        = r_stall_cnt;
  assign out_IF_ID_Opcode       = r_instr[31:26];
  assign out_IF_ID_Rs_Address   = r_instr[25:21];
  assign out_IF_ID_Rt_Address   = r_instr[20:16];
  assign out_IF_ID_Rd_Address   = r_instr[15:11];
  assign out_IF_ID_Shift_Amount = r_instr[10:6];
  assign out_IF_ID_Funct        = r_instr[5:0];
  assign out_IF_ID_Immidiate    = r_instr[15:0];
  assign out_IF_ID_Jump_Target  = r_instr[25:0];

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Testbench for if_id_pipe_reg.
// Stimulus is driven on the falling edge. A reference model pushes the
// expected register contents into a queue. A monitor pops one entry after
// each rising edge and compares it with the DUT.
// A second instance with a 4-bit counter exercises saturation.
module tb_if_id_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_stall;
  logic        in_flush;

  logic [31:0] o_pc, o_instr, o2_pc, o2_instr;
  logic        o_valid, o2_valid;
  logic [5:0]  o_op, o_fn, o2_op, o2_fn;
  logic [4:0]  o_rs, o_rt, o_rd, o_sh, o2_rs, o2_rt, o2_rd, o2_sh;
  logic [15:0] o_imm, o2_imm;
  logic [25:0] o_jt, o2_jt;
  logic [15:0] o_cnt;
  logic [3:0]  o2_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
    int          cnt;
    int          cnt4;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_valid;
  int          m_cnt;
  int          m_cnt4;

  always #5 clk = ~clk;

  if_id_pipe_reg dut (
    .clk(clk), .rst(rst),
    .in_IF_PC_Plus4(in_pc), .in_IF_Instruction(in_instr), .in_IF_Valid(in_valid),
    .in_Stall(in_stall), .in_Flush(in_flush),
    .out_IF_ID_PC_Plus4(o_pc), .out_IF_ID_Instruction(o_instr), .out_IF_ID_Valid(o_valid),
    .out_IF_ID_Opcode(o_op), .out_IF_ID_Rs_Address(o_rs), .out_IF_ID_Rt_Address(o_rt),
    .out_IF_ID_Rd_Address(o_rd), .out_IF_ID_Shift_Amount(o_sh), .out_IF_ID_Funct(o_fn),
    .out_IF_ID_Immidiate(o_imm), .out_IF_ID_Jump_Target(o_jt), .out_Stall_Count(o_cnt)
  );

  if_id_pipe_reg #(.STALL_CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_IF_PC_Plus4(in_pc), .in_IF_Instruction(in_instr), .in_IF_Valid(in_valid),
    .in_Stall(in_stall), .in_Flush(in_flush),
    .out_IF_ID_PC_Plus4(o2_pc), .out_IF_ID_Instruction(o2_instr), .out_IF_ID_Valid(o2_valid),
    .out_IF_ID_Opcode(o2_op), .out_IF_ID_Rs_Address(o2_rs), .out_IF_ID_Rt_Address(o2_rt),
    .out_IF_ID_Rd_Address(o2_rd), .out_IF_ID_Shift_Amount(o2_sh), .out_IF_ID_Funct(o2_fn),
    .out_IF_ID_Immidiate(o2_imm), .out_IF_ID_Jump_Target(o2_jt), .out_Stall_Count(o2_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. The model applies the block's rules and the
  // resulting contents are queued for the monitor.
  task automatic step(input logic r, input logic [31:0] pc, input logic [31:0] ins,
                      input logic v, input logic st, input logic fl);
    exp_t e;
    @(negedge clk);
    rst = r; in_pc = pc; in_instr = ins; in_valid = v; in_stall = st; in_flush = fl;
    if (r) begin
      m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_cnt = 0; m_cnt4 = 0;
    end else if (fl) begin
      m_instr = 32'h0; m_valid = 1'b0; m_pc = pc;
    end else if (st) begin
      if (m_valid) begin
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
        if (m_cnt4 < 15) m_cnt4 = m_cnt4 + 1;
      end
    end else begin
      m_valid = v; m_pc = pc; m_instr = v ? ins : 32'h0;
    end
    e.instr = m_instr; e.pc = m_pc; e.valid = m_valid; e.cnt = m_cnt; e.cnt4 = m_cnt4;
    exp_q.push_back(e);
  endtask

  task automatic load(input logic [31:0] pc, input logic [31:0] ins);
    step(1'b0, pc, ins, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic stall_n(input int n);
    for (int k = 0; k < n; k++) step(1'b0, $urandom, $urandom, 1'($urandom), 1'b1, 1'b0);
  endtask

  // Monitor: compare every DUT output with the queued expectation, 1 ns after each rising edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("instr", o_instr, e.instr);
        chk("pc_plus4", o_pc, e.pc);
        chk("valid", {31'h0, o_valid}, {31'h0, e.valid});
        chk("opcode", {26'h0, o_op}, e.instr >> 26);
        chk("rs", {27'h0, o_rs}, (e.instr >> 21) & 32'h1F);
        chk("rt", {27'h0, o_rt}, (e.instr >> 16) & 32'h1F);
        chk("rd", {27'h0, o_rd}, (e.instr >> 11) & 32'h1F);
        chk("shamt", {27'h0, o_sh}, (e.instr >> 6) & 32'h1F);
        chk("funct", {26'h0, o_fn}, e.instr & 32'h3F);
        chk("imm", {16'h0, o_imm}, e.instr & 32'hFFFF);
        chk("jtarget", {6'h0, o_jt}, e.instr & 32'h03FF_FFFF);
        chk("stall_cnt", {16'h0, o_cnt}, e.cnt);
        chk("stall_cnt4", {28'h0, o2_cnt}, e.cnt4);
        chk("instr_w4", o2_instr, e.instr);
        chk("valid_w4", {31'h0, o2_valid}, {31'h0, e.valid});
      end
    end
  end

  initial begin : stim
    int r;
    rst = 1'b1; in_pc = 32'h0; in_instr = 32'h0; in_valid = 1'b0; in_stall = 1'b0; in_flush = 1'b0;
    m_instr = 32'h0; m_pc = 32'h0; m_valid = 1'b0; m_cnt = 0; m_cnt4 = 0;

    // Reset for two cycles, then load lw $2,4($1)
    step(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    step(1'b1, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1);
    load(32'h0000_0008, 32'h8C22_0004);
    // Load add $3,$1,$2, then hold it through three stalls while the inputs change
    load(32'h0000_000C, 32'h0022_1820);
    stall_n(3);
    // Flush and stall together: flush wins and the counter is unchanged
    load(32'h0000_0010, 32'h2021_0001);
    step(1'b0, 32'h0000_0040, 32'hABCD_1234, 1'b1, 1'b1, 1'b1);
    // Stalls that hold a bubble are not counted
    stall_n(4);
    // Hold a valid entry for 20 stalls: the 4-bit counter saturates at 15
    load(32'h0000_0014, 32'h0C00_1234);
    stall_n(20);
    // Invalid fetch with a garbage word loads a bubble
    step(1'b0, 32'h0000_0018, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    // Reset asserted during a stall
    load(32'h0000_001C, 32'h0043_2025);
    stall_n(2);
    step(1'b1, 32'h0000_0020, 32'h1111_2222, 1'b1, 1'b1, 1'b0);
    step(1'b0, 32'h0000_0024, 32'h3333_4444, 1'b1, 1'b0, 1'b0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      step(1'b0 | (r < 2), $urandom, $urandom, ($urandom_range(0, 9) < 8),
           ($urandom_range(0, 9) < 4), ($urandom_range(0, 9) < 1));
    end

    // Allow the monitor to drain the queue, within a bounded number of cycles
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d expected=0 entries left in queue", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
